// File: rtl/charge_meter.sv
// Air-conditioner charge meter: synchronised tick counting, metered seconds and saturating bill.
// Optional CHARGE_MIN_BILL_EN: bill one minute up front on each IDLE->RUN start.
module charge_meter #(
    parameter int TICKS_PER_SEC = 500,
    parameter int RATE_COOL     = 5,
    parameter int RATE_HEAT     = 8,
    parameter int RATE_FAN      = 2,
    parameter int CHARGE_MAX    = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic        clr,
    output logic [15:0] seconds,
    output logic [13:0] charge,
    output logic        sec_pulse,
    output logic        running,
    output logic        sat
);

    localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_SEC - 1);
    localparam logic [14:0]   MAX15    = 15'(CHARGE_MAX);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

    state_t state, nxt;

    logic          s1, s2, s3, tick;
    logic [SW-1:0] sub;
    logic [5:0]    min_cnt;
    logic [13:0]   rate;
    logic [14:0]   sum;
    logic          minute_wrap, add_en, sat_hit;
    logic          count_ok, sec_adv;

`ifdef CHARGE_MIN_BILL_EN
    logic skip;
    logic start_bill;
    assign start_bill = (state == IDLE) && en && !clr;
    assign add_en     = (minute_wrap && !skip) || start_bill;
`else
    assign add_en     = minute_wrap;
`endif

    always_comb begin
        rate = 14'(RATE_FAN);
        unique case (mode)
            2'b01:   rate = 14'(RATE_COOL);
            2'b10:   rate = 14'(RATE_HEAT);
            default: rate = 14'(RATE_FAN);
        endcase
    end

    assign sum         = {1'b0, charge} + {1'b0, rate};
    assign minute_wrap = sec_pulse && (min_cnt == 6'd59);
    assign sat_hit     = add_en && (sum >= MAX15);
    // a tick racing the saturating add is dropped so SAT freezes cleanly
    assign count_ok    = tick && (state == RUN) && en && !sat_hit;
    assign sec_adv     = count_ok && (sub == SUB_LAST)
                         && (seconds != 16'hFFFF);

    assign running = (state == RUN);
    assign sat     = (state == SAT);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (en) nxt = RUN;
            RUN:     if (!en) nxt = PAUSE;
            PAUSE:   if (en) nxt = RUN;
            SAT:     nxt = SAT;
            default: nxt = IDLE;
        endcase
        if (sat_hit) nxt = SAT;
        if (clr) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            tick  <= 1'b0;
        end else begin
            state <= nxt;
            s1    <= tick_in;
            s2    <= s1;
            s3    <= s2;
            tick  <= s2 & ~s3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub       <= '0;
            min_cnt   <= '0;
            seconds   <= '0;
            charge    <= '0;
            sec_pulse <= 1'b0;
        end else if (clr) begin
            sub       <= '0;
            min_cnt   <= '0;
            seconds   <= '0;
            charge    <= '0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= sec_adv;
            if (count_ok)
                sub <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
            if (sec_adv)
                seconds <= seconds + 16'd1;
            if (sec_pulse)
                min_cnt <= minute_wrap ? 6'd0 : min_cnt + 6'd1;
            if (add_en)
                charge <= sat_hit ? MAX15[13:0] : sum[13:0];
        end
    end

`ifdef CHARGE_MIN_BILL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            skip <= 1'b0;
        else if (clr)
            skip <= 1'b0;
        else if (start_bill)
            skip <= 1'b1;
        else if (minute_wrap)
            skip <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_charge_meter.sv
// Directed bench for charge_meter with TICKS_PER_SEC=2; a second instance uses CHARGE_MAX=10 in heat mode.
module tb_charge_meter;

`ifdef CHARGE_MIN_BILL_EN
    localparam bit MB = 1'b1;
`else
    localparam bit MB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_in = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b01;
    logic        clr = 1'b0;
    logic [15:0] seconds0, seconds1;
    logic [13:0] charge0, charge1;
    logic        sp0, sp1, run0, run1, sat0, sat1;

    int n_chk = 0;
    int n_fail = 0;
    int n_sp0 = 0;
    int n_sp1 = 0;
    int mark;
    bit found;

    always #5 clk = ~clk;

    charge_meter #(.TICKS_PER_SEC(2)) u0 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .mode(mode),
        .clr(clr), .seconds(seconds0), .charge(charge0), .sec_pulse(sp0),
        .running(run0), .sat(sat0)
    );

    charge_meter #(.TICKS_PER_SEC(2), .CHARGE_MAX(10)) u1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .mode(2'b10),
        .clr(clr), .seconds(seconds1), .charge(charge1), .sec_pulse(sp1),
        .running(run1), .sat(sat1)
    );

    always @(negedge clk) begin
        if (sp0) n_sp0++;
        if (sp1) n_sp1++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_once();
        tick_in = 1'b1;
        repeat (4) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    // raise tick_in and stop at the negedge where sec_pulse shows
    task automatic tick_to_pulse(output bit ok);
        ok = 1'b0;
        tick_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sp0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1;
        check("reset_seconds", seconds0, 0);
        check("reset_charge", charge0, 0);
        check("reset_flags", {sp0, run0, sat0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_not_running", run0, 0);

        // one full minute in cool mode
        en = 1'b1;
        mode = 2'b01;
        @(negedge clk);
        check("run_after_en", run0, 1);
        ticks(119);
        tick_to_pulse(found);
        check("pulse60_seen", found, 1);
        check("pulse60_seconds", seconds0, 60);
        check("pulse60_charge_before", charge0, MB ? 5 : 0);
        @(negedge clk);
        check("minute_charge_after", charge0, 5);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        check("heat_minute_charge", charge1, 8);

        // second minute saturates the CHARGE_MAX=10 instance
        ticks(120);
        check("sat_charge", charge1, 10);
        check("sat_flag", sat1, 1);
        check("sat_seconds", seconds1, 120);
        check("two_minute_charge", charge0, 10);
        mark = n_sp1;
        ticks(4);
        check("sat_frozen_seconds", seconds1, 120);
        check("sat_no_pulse", n_sp1 - mark, 0);
        check("sat_not_running", run1, 0);
        check("unsat_seconds", seconds0, 122);

        // clear with en held high, RUN on the cycle after clr drops
        clr = 1'b1;
        @(negedge clk);
        check("clr_seconds", seconds0, 0);
        check("clr_charge", charge0, 0);
        check("clr_idle", run0, 0);
        check("clr_exits_sat", sat1, 0);
        clr = 1'b0;
        @(negedge clk);
        check("run_after_clr", run0, 1);
        check("start_bill_charge", charge0, MB ? 5 : 0);

        // clr lands on the 60th sec_pulse and wins over the minute add
        ticks(119);
        tick_to_pulse(found);
        check("clr_pulse_seen", found, 1);
        clr = 1'b1;
        @(negedge clk);
        check("clr60_seconds", seconds0, 0);
        check("clr60_charge", charge0, 0);
        check("clr60_idle", run0, 0);
        clr = 1'b0;
        tick_in = 1'b0;
        @(negedge clk);
        check("clr60_run", run0, 1);
        repeat (3) @(negedge clk);

        // pause holds the sub-second count
        ticks(3);
        check("pre_pause_seconds", seconds0, 1);
        en = 1'b0;
        @(negedge clk);
        check("pause_not_running", run0, 0);
        mark = n_sp0;
        ticks(10);
        check("pause_no_pulse", n_sp0 - mark, 0);
        check("pause_seconds", seconds0, 1);
        en = 1'b1;
        @(negedge clk);
        ticks(1);
        check("resume_seconds", seconds0, 2);
        check("resume_running", run0, 1);

        // asynchronous reset mid-minute
        ticks(56);
        check("mid_seconds", seconds0, 30);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_seconds", seconds0, 0);
        check("async_charge", charge0, 0);
        check("async_flags", {sp0, run0, sat0}, 0);
        en = 1'b0;
        mode = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_charge", charge0, 0);

        // fan mode billing from a fresh start
        en = 1'b1;
        @(negedge clk);
        check("fan_start_running", run0, 1);
        check("fan_start_charge", charge0, MB ? 2 : 0);
        ticks(120);
        check("fan_60s_charge", charge0, 2);
        ticks(120);
        check("fan_120s_charge", charge0, 4);
        check("fan_120s_seconds", seconds0, 120);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/charge_meter.md
CHARGE_METER -- requirements
Module: charge_meter

Interface
REQ-001 Parameter TICKS_PER_SEC, default 500: number of slow-clock rising edges per second of metered time.
REQ-002 Parameter RATE_COOL, default 5: charge units added per metered minute in cool mode.
REQ-003 Parameter RATE_HEAT, default 8: charge units added per metered minute in heat mode.
REQ-004 Parameter RATE_FAN, default 2: charge units added per metered minute in fan mode.
REQ-005 Parameter CHARGE_MAX, default 9999: saturation ceiling of the charge total.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 tick_in  input  1  level output of the upstream clock divider, asynchronous to clk.
REQ-009 en  input  1  air conditioner running; metering is enabled while high.
REQ-010 mode  input  2  00 fan, 01 cool, 10 heat, 11 treated as fan.
REQ-011 clr  input  1  synchronous clear of the bill, active-high, one or more cycles long.
REQ-012 seconds  output  16  metered seconds since last clear.
REQ-013 charge  output  14  accumulated charge units.
REQ-014 sec_pulse  output  1  one-clk pulse each time seconds advances.
REQ-015 running  output  1  high in RUN state.
REQ-016 sat  output  1  high in SAT state.

Function
REQ-017 tick_in shall pass through a two-flop synchroniser; a rising edge of the synchronised level shall produce a one-clk tick pulse 3 clk cycles after tick_in rises.
REQ-018 FSM states: IDLE, RUN, PAUSE, SAT.
REQ-019 Transitions: IDLE->RUN and PAUSE->RUN when en=1; RUN->PAUSE when en=0; RUN->SAT when charge reaches CHARGE_MAX; any state->IDLE when clr=1.
REQ-020 A tick pulse shall count only in a cycle where state is RUN and en=1; in the same cycle as RUN->PAUSE, the tick shall be dropped.
REQ-021 Sub-second counter runs 0..TICKS_PER_SEC-1; the tick that arrives at TICKS_PER_SEC-1 wraps it to 0, asserts sec_pulse in the next cycle and increments seconds.
REQ-022 seconds shall saturate at 65535 and shall not wrap.
REQ-023 Second-in-minute counter runs 0..59; on the sec_pulse that wraps it from 59 to 0, charge adds the rate of mode as sampled in that cycle.
REQ-024 The charge addition shall saturate at CHARGE_MAX, never exceeding it, and shall enter SAT in the same cycle.
REQ-025 In SAT, all counters shall freeze and sec_pulse shall stay 0; only clr or reset shall exit SAT.
REQ-026 In PAUSE, all counters shall hold, and metering shall resume from the held sub-second value.
REQ-027 clr shall have priority over every tick or minute event in the same cycle: counters, seconds and charge go to 0 and state goes to IDLE.
REQ-028 If en=1 while clr=1, the FSM shall enter RUN on the first cycle after clr deasserts.

Reset
REQ-029 With rst=0, asynchronously: state IDLE; seconds=0; charge=0; sec_pulse=0; running=0; sat=0; synchroniser flops, edge register and all counters at 0.
REQ-030 Reset asserted mid-operation shall discard the bill in progress; no partial minute shall be charged.

Configuration
REQ-031 Macro CHARGE_MIN_BILL_EN defined: on each IDLE->RUN transition, charge shall add the current mode's rate in that cycle, and the first minute wrap after that transition shall add nothing; PAUSE->RUN shall not bill.
REQ-032 Macro CHARGE_MIN_BILL_EN undefined: nothing is charged until the first full metered minute completes.

Verification (TICKS_PER_SEC=2)
REQ-033 Stimulus: en=1, mode=01, 120 tick_in edges. Required: seconds=60, charge=5, with the add in the cycle after the 60th sec_pulse (macro off).
REQ-034 Stimulus: en=1 for 3 ticks, en=0 for 10 ticks, en=1 for 1 tick. Required: seconds=2, running=0 during the pause, no sec_pulse during the pause.
REQ-035 Stimulus: CHARGE_MAX=10, mode=10, 2 minutes. Required: charge=10, sat=1, seconds frozen at 120 despite further ticks.
REQ-036 Stimulus: clr pulsed in the same cycle as the 60th sec_pulse. Required: seconds=0, charge=0, state IDLE, then RUN one cycle after clr drops.
REQ-037 Stimulus: rst=0 asserted mid-minute at seconds=30. Required: all outputs 0 immediately, without waiting for a clk edge.
REQ-038 Stimulus: macro on, en rises with mode=00. Required: charge=2 one cycle later, and charge=2 still after 60 seconds, then 4 after 120 seconds.
